// File: rtl/isr_controller_if.sv
// Bundle of the interrupt controller's pipeline-side signals.
// Handshake: the controller has no valid/ready pair of its own. A redirect
// is accepted by the pipeline in the same cycle that ISR_PC_flush and
// ISR_pipe_flush are high. Those two strobes are always equal. isr_pc is
// meaningful only while the strobes are high and reads 0 otherwise.
interface isr_controller_if;
    logic [3:0]  int_sig;
    logic [3:0]  int_mask;
    logic        gie;
    logic [11:0] id_pc;
    logic        id_valid;
    logic        id_is_uret;
    logic        pipe_stall;
    logic        branch_flush;
    logic        jump_flush;
    logic        ISR_PC_flush;
    logic        ISR_pipe_flush;
    logic [11:0] isr_pc;
    logic        ISR_running;
    logic [1:0]  isr_idx;
    logic [11:0] saved_pc;
    logic [1:0]  state_dbg;

    // Pipeline / interrupt sources side
    modport master (
        output int_sig, int_mask, gie, id_pc, id_valid, id_is_uret,
               pipe_stall, branch_flush, jump_flush,
        input  ISR_PC_flush, ISR_pipe_flush, isr_pc, ISR_running,
               isr_idx, saved_pc, state_dbg
    );

    // Controller side
    modport slave (
        input  int_sig, int_mask, gie, id_pc, id_valid, id_is_uret,
               pipe_stall, branch_flush, jump_flush,
        output ISR_PC_flush, ISR_pipe_flush, isr_pc, ISR_running,
               isr_idx, saved_pc, state_dbg
    );
endinterface

// File: rtl/isr_controller.sv
// Interrupt entry/return controller. It latches request edges, picks the
// lowest eligible line, waits for a clean pipeline cycle to redirect to the
// vector, and on uret redirects back to the saved return address.
module isr_controller #(
    parameter logic [11:0] VEC_BASE = 12'hF00
) (
    input logic             clk,
    input logic             nrst,
    isr_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_RET} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  sig_dly_q, sig_dly_d;
    logic [11:0] saved_pc_q, saved_pc_d;
    logic [1:0]  isr_idx_q, isr_idx_d;

    logic [3:0]  rise;
    logic [3:0]  eligible;
    logic [3:0]  clr;
    logic [1:0]  win_idx;
    logic        win_valid;
    logic        path_clear;
    logic        cur_ok;
    logic        flush;
    logic [11:0] pc_out;

    assign rise       = bus.int_sig & ~sig_dly_q;
    assign eligible   = bus.gie ? (pend_q & bus.int_mask) : 4'b0000;
    assign path_clear = ~bus.pipe_stall & ~bus.branch_flush & ~bus.jump_flush;
    // The armed line must still be pending, unmasked and globally enabled.
    assign cur_ok     = bus.gie & bus.int_mask[isr_idx_q] & pend_q[isr_idx_q];

    // Priority pick: the lowest eligible index wins.
    always_comb begin
        win_idx   = 2'd0;
        win_valid = |eligible;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) win_idx = 2'(i);
        end
    end

    // Next-state, pending bookkeeping and redirect strobes.
    always_comb begin
        state_d    = state_q;
        isr_idx_d  = isr_idx_q;
        saved_pc_d = saved_pc_q;
        clr        = 4'b0000;
        flush      = 1'b0;
        pc_out     = 12'h000;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d   = S_ARM;
                    isr_idx_d = win_idx;
                end
            end
            S_ARM: begin
                if (!cur_ok) begin
                    // Enable withdrawn: back off quietly, the request stays pending.
                    state_d = S_IDLE;
                end else if (path_clear && bus.id_valid) begin
                    flush          = 1'b1;
                    pc_out         = VEC_BASE + {6'b000000, isr_idx_q, 4'b0000};
                    saved_pc_d     = bus.id_pc;
                    clr[isr_idx_q] = 1'b1;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.id_is_uret && bus.id_valid) state_d = S_RET;
            end
            S_RET: begin
                if (path_clear) begin
                    flush   = 1'b1;
                    pc_out  = saved_pc_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new edge in the same cycle as the clear keeps the line pending.
        pend_d    = (pend_q & ~clr) | rise;
        sig_dly_d = bus.int_sig;

        if (!nrst) begin
            state_d    = S_IDLE;
            isr_idx_d  = 2'd0;
            saved_pc_d = 12'h000;
            pend_d     = 4'b0000;
            sig_dly_d  = 4'b0000;
            flush      = 1'b0;
            pc_out     = 12'h000;
        end
    end

    // State registers; reset is folded into the _d logic above.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        pend_q     <= pend_d;
        sig_dly_q  <= sig_dly_d;
        saved_pc_q <= saved_pc_d;
        isr_idx_q  <= isr_idx_d;
    end

    assign bus.ISR_PC_flush   = flush;
    assign bus.ISR_pipe_flush = flush;
    assign bus.isr_pc         = pc_out;
    assign bus.ISR_running    = (state_q == S_RUN) || (state_q == S_RET);
    assign bus.isr_idx        = isr_idx_q;
    assign bus.saved_pc       = saved_pc_q;
    assign bus.state_dbg      = state_q;
endmodule

// File: doc/isr_controller.md
ISR_CONTROLLER -- requirements
Module: isr_controller

Interface
REQ-001 Parameter: VEC_BASE, 12'hF00, base of the interrupt vector table; vector = VEC_BASE + {idx,4'b0000}.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 nrst  in  1  reset, synchronous, active-low.
REQ-004 int_sig  in  4  external interrupt request lines, level, already synchronous to clk.
REQ-005 int_mask  in  4  per-line enable; 1 = line may be taken.
REQ-006 gie  in  1  global interrupt enable.
REQ-007 id_pc  in  12  PC of the instruction in ID.
REQ-008 id_valid  in  1  ID holds a real instruction, not a bubble.
REQ-009 id_is_uret  in  1  ID holds the return-from-interrupt instruction.
REQ-010 pipe_stall  in  1  IF/ID stall from the stall/flush controller.
REQ-011 branch_flush, jump_flush  in  1 each  redirect in progress.
REQ-012 ISR_PC_flush  out  1  PC redirect strobe.
REQ-013 ISR_pipe_flush  out  1  IF/ID flush strobe.
REQ-014 isr_pc  out  12  redirect target, valid when ISR_PC_flush=1.
REQ-015 ISR_running  out  1  handler executing.
REQ-016 isr_idx  out  2  index of the line being serviced.
REQ-017 saved_pc  out  12  return address.

Function
REQ-018 Pending: pend[i] is set on a rising edge of int_sig[i], detected with a 1-cycle delayed copy of int_sig, and stays set until serviced; a repeated edge on an already-pending line is absorbed.
REQ-019 Eligible = pend & int_mask, gated by gie; lowest index has highest priority.
REQ-020 States: IDLE, ARM, RUN, RET.
REQ-021 IDLE -> ARM when eligible is nonzero; the winning idx is latched into isr_idx on that transition.
REQ-022 A clean cycle is pipe_stall=0 & branch_flush=0 & jump_flush=0 & id_valid=1.
REQ-023 In ARM, outputs are held low and the state is held until a clean cycle occurs.
REQ-024 In the clean ARM cycle, combinationally:
  - ISR_PC_flush=1, ISR_pipe_flush=1;
  - isr_pc = VEC_BASE + {isr_idx,4'b0}.
REQ-025 At the clock edge ending the clean ARM cycle: saved_pc <= id_pc, pend[isr_idx] <= 0, and state -> RUN.
REQ-026 ISR_running=1 in RUN and RET, 0 otherwise.
REQ-027 In RUN, new edges still set pend, but no nesting occurs.
REQ-028 RUN -> RET when id_is_uret=1 & id_valid=1.
REQ-029 In RET, in the first cycle with pipe_stall=0 & branch_flush=0 & jump_flush=0:
  - ISR_PC_flush=1, ISR_pipe_flush=1, isr_pc=saved_pc;
  - next state IDLE.
  - Otherwise RET holds with outputs low.
REQ-030 From IDLE after a return, a still-pending eligible line re-enters ARM on the following cycle, so there is at least 1 idle cycle between handlers.
REQ-031 If gie or int_mask drops while in ARM, the state returns to IDLE without flushing, and pend is kept.
REQ-032 An edge on the line being serviced arriving in the same cycle as its clear leaves pend[i]=1; set wins.
REQ-033 ISR_PC_flush and ISR_pipe_flush are always equal and each lasts exactly 1 cycle per entry or return.

Reset
REQ-034 With nrst=0 at a rising edge:
  - state=IDLE, pend=0, delayed int_sig copy=0;
  - saved_pc=0, isr_idx=0;
  - all outputs 0, isr_pc=0.
REQ-035 Reset mid-ARM, mid-RUN or mid-RET aborts with no flush strobe, and pending requests are discarded.

Verification
REQ-036 Basic entry: gie=1, mask=4'hF, pulse int_sig[2] at cycle 0, clean pipeline, id_pc=12'h040 -> flush strobes 1 cycle at cycle 2, isr_pc=12'hF20, saved_pc=12'h040, ISR_running=1 from cycle 3.
REQ-037 Priority: edges on lines 1 and 3 in the same cycle -> line 1 serviced first (isr_pc=12'hF10); after uret, line 3 is serviced with isr_pc=12'hF30.
REQ-038 Blocking: pipe_stall=1 for 3 cycles in ARM, then a branch_flush cycle -> no strobe until the first clean cycle, then exactly one strobe.
REQ-039 Return: in RUN assert id_is_uret with pipe_stall=1 for 2 cycles -> strobe on the 3rd cycle with isr_pc=saved_pc, ISR_running=0 the cycle after.
REQ-040 Masking: mask[0]=0 with an edge on line 0 -> no entry; set mask[0]=1 -> entry with isr_pc=12'hF00.
REQ-041 Reset in RUN with pend[2]=1 -> all outputs 0, and no entry afterwards without a new edge.
